// File: rtl/dsa_uart_pkg.sv
// dsa_uart_pkg: command codes, response bytes, FSM states and STATUS layout
package dsa_uart_pkg;
  localparam logic [7:0] CMD_CONFIG   = 8'h01;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STATUS   = 8'h05;
  localparam logic [7:0] CMD_COUNTER  = 8'h06;
  localparam logic [7:0] CMD_SET_ADDR = 8'h07;
  localparam logic [7:0] CMD_RESET    = 8'h08;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'hFF;
  localparam int ST_BUSY  = 0;
  localparam int ST_READY = 1;
  localparam int ST_ERROR = 2;
  localparam int ST_FERR  = 3;
  localparam int ST_PROG  = 16;
  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_WR_DATA, S_CHK, S_EXEC,
    S_SEND_ACK, S_SEND_NAK, S_SEND_RESP, S_RD_REQ, S_RD_WAIT, S_RD_SEND
  } state_e;
  function automatic logic known_cmd(input logic [7:0] c);
    return c >= CMD_CONFIG && c <= CMD_RESET;
  endfunction
  function automatic logic rx_state(input state_e s);
    return s inside {S_LEN, S_PAYLOAD, S_WR_DATA, S_CHK};
  endfunction
endpackage

// File: rtl/dsa_uart_cmd_engine_if.sv
// dsa_uart_cmd_engine_if: UART byte streams plus byte-wide memory port
interface dsa_uart_cmd_engine_if #(parameter int ADDR_W = 18);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport master (input rx_valid, rx_data, tx_ready, mem_rdata,
                  output tx_valid, tx_data, mem_we, mem_re, mem_addr, mem_wdata);
  modport slave  (output rx_valid, rx_data, tx_ready, mem_rdata,
                  input tx_valid, tx_data, mem_we, mem_re, mem_addr, mem_wdata);
endinterface

// File: rtl/dsa_uart_frame_timer.sv
// dsa_uart_frame_timer: inter-byte idle down-counter, reloaded on clear or while disabled
module dsa_uart_frame_timer #(parameter int TIMEOUT_CYC = 500000) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // reload on every received byte or outside receive states, otherwise count down to zero
  always_comb cnt_d = (clr || !en) ? W'(TIMEOUT_CYC - 1) : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  assign expired = en && !clr && cnt_q == '0;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= W'(TIMEOUT_CYC - 1);
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dsa_uart_cmd_engine.sv
// dsa_uart_cmd_engine: framed UART command decoder driving dsa_top config, memory bursts and status readback
module dsa_uart_cmd_engine import dsa_uart_pkg::*; #(
  parameter int ADDR_W      = 18,
  parameter int LEN_W       = 16,
  parameter int NUM_CNT     = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  dsa_uart_cmd_engine_if.master bus,
  output logic                 dsa_start,
  output logic                 dsa_soft_rst,
  output logic                 dsa_mode_simd,
  output logic [9:0]           dsa_img_width_in,
  output logic [9:0]           dsa_img_height_in,
  output logic [7:0]           dsa_scale_factor,
  input  logic                 dsa_busy,
  input  logic                 dsa_ready,
  input  logic                 dsa_error,
  input  logic [15:0]          dsa_progress,
  input  logic [NUM_CNT*32-1:0] cnt_bus,
  output logic                 frame_err
);
  localparam logic [2:0] LEN_B = 3'(LEN_W / 8);
  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d, chk_q, chk_d, wdata_q, wdata_d, scale_q, scale_d;
  logic [31:0]       pay_q, pay_d, resp_q, resp_d;
  logic [2:0]        bcnt_q, bcnt_d, need;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        width_q, width_d, height_q, height_d;
  logic              ok_q, ok_d, we_q, we_d, start_q, start_d, srst_q, srst_d;
  logic              simd_q, simd_d, ferr_q, ferr_d, tmo;

  dsa_uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk), .rst(rst), .en(rx_state(state_q)), .clr(bus.rx_valid), .expired(tmo)
  );

  assign need = cmd_q == CMD_COUNTER ? 3'd1 : state_q == S_LEN ? LEN_B : 3'd4;

  // frame parsing, command execution and response sequencing
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    chk_d = chk_q;
    pay_d = pay_q;
    bcnt_d = bcnt_q;
    rem_d = rem_q;
    ok_d = ok_q;
    resp_d = resp_q;
    addr_d = we_q ? addr_q + 1'b1 : addr_q;
    we_d = 1'b0;
    wdata_d = wdata_q;
    start_d = 1'b0;
    srst_d = 1'b0;
    simd_d = simd_q;
    width_d = width_q;
    height_d = height_q;
    scale_d = scale_q;
    ferr_d = ferr_q;
    unique case (state_q)
      S_IDLE: if (bus.rx_valid) begin
        cmd_d = bus.rx_data;
        chk_d = bus.rx_data;
        bcnt_d = '0;
        pay_d = '0;
        ferr_d = ferr_q | !known_cmd(bus.rx_data);
        state_d = !known_cmd(bus.rx_data) ? S_SEND_NAK
                : bus.rx_data inside {CMD_WRITE, CMD_READ} ? S_LEN
                : bus.rx_data inside {CMD_CONFIG, CMD_SET_ADDR, CMD_COUNTER} ? S_PAYLOAD : S_CHK;
      end
      S_LEN, S_PAYLOAD: if (bus.rx_valid) begin
        chk_d = chk_q ^ bus.rx_data;
        pay_d = {bus.rx_data, pay_q[31:8]};
        bcnt_d = bcnt_q + 3'd1;
        rem_d = state_q == S_LEN ? pay_d[31 -: LEN_W] : rem_q;
        if (bcnt_d == need)
          state_d = (state_q == S_LEN && cmd_q == CMD_WRITE && rem_d != '0) ? S_WR_DATA : S_CHK;
      end
      S_WR_DATA: if (bus.rx_valid) begin
        chk_d = chk_q ^ bus.rx_data;
        we_d = 1'b1;
        wdata_d = bus.rx_data;
        rem_d = rem_q - 1'b1;
        state_d = rem_q == LEN_W'(1) ? S_CHK : S_WR_DATA;
      end
      S_CHK: if (bus.rx_valid) begin
        ok_d = chk_q == bus.rx_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_SEND_ACK;
        bcnt_d = '0;
        if (!ok_q) begin
          state_d = S_SEND_NAK;
          ferr_d = 1'b1;
        end else if (cmd_q == CMD_CONFIG) begin
          width_d = pay_q[31:22];
          height_d = pay_q[21:12];
          scale_d = pay_q[11:4];
          simd_d = pay_q[0];
        end else if (cmd_q == CMD_SET_ADDR) begin
          addr_d = pay_q[ADDR_W-1:0];
        end else if (cmd_q == CMD_START) begin
          state_d = dsa_busy ? S_SEND_NAK : S_SEND_ACK;
          start_d = !dsa_busy;
        end else if (cmd_q == CMD_STATUS) begin
          resp_d = '0;
          resp_d[ST_PROG +: 16] = dsa_progress;
          resp_d[ST_FERR] = ferr_q;
          resp_d[ST_ERROR] = dsa_error;
          resp_d[ST_READY] = dsa_ready;
          resp_d[ST_BUSY] = dsa_busy;
        end else if (cmd_q == CMD_COUNTER) begin
          state_d = 32'(pay_q[31:24]) >= NUM_CNT ? S_SEND_NAK : S_SEND_ACK;
          resp_d = 32'(cnt_bus >> {pay_q[31:24], 5'd0});
        end else if (cmd_q == CMD_RESET) begin
          srst_d = 1'b1;
          ferr_d = 1'b0;
        end
      end
      S_SEND_ACK: if (bus.tx_ready)
        state_d = cmd_q inside {CMD_STATUS, CMD_COUNTER} ? S_SEND_RESP
                : (cmd_q == CMD_READ && rem_q != '0) ? S_RD_REQ : S_IDLE;
      S_SEND_NAK: if (bus.tx_ready) state_d = S_IDLE;
      S_SEND_RESP: if (bus.tx_ready) begin
        resp_d = resp_q >> 8;
        bcnt_d = bcnt_q + 3'd1;
        state_d = bcnt_q == 3'd3 ? S_IDLE : S_SEND_RESP;
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        resp_d = {24'h0, bus.mem_rdata};
        state_d = S_RD_SEND;
      end
      S_RD_SEND: if (bus.tx_ready) begin
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = rem_q == LEN_W'(1) ? S_IDLE : S_RD_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d = S_SEND_NAK;
      ferr_d = 1'b1;
    end
    if (bus.rx_valid && state_q != S_IDLE && !rx_state(state_q)) ferr_d = 1'b1;
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q <= '0;
      chk_q <= '0;
      pay_q <= '0;
      bcnt_q <= '0;
      rem_q <= '0;
      ok_q <= 1'b0;
      resp_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      start_q <= 1'b0;
      srst_q <= 1'b0;
      simd_q <= 1'b0;
      width_q <= '0;
      height_q <= '0;
      scale_q <= 8'h80;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      chk_q <= chk_d;
      pay_q <= pay_d;
      bcnt_q <= bcnt_d;
      rem_q <= rem_d;
      ok_q <= ok_d;
      resp_q <= resp_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      srst_q <= srst_d;
      simd_q <= simd_d;
      width_q <= width_d;
      height_q <= height_d;
      scale_q <= scale_d;
      ferr_q <= ferr_d;
    end

  assign bus.tx_valid = state_q inside {S_SEND_ACK, S_SEND_NAK, S_SEND_RESP, S_RD_SEND};
  assign bus.tx_data = state_q == S_SEND_ACK ? ACK : state_q == S_SEND_NAK ? NAK : resp_q[7:0];
  assign bus.mem_re = state_q == S_RD_REQ;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign dsa_start = start_q;
  assign dsa_soft_rst = srst_q;
  assign dsa_mode_simd = simd_q;
  assign dsa_img_width_in = width_q;
  assign dsa_img_height_in = height_q;
  assign dsa_scale_factor = scale_q;
  assign frame_err = ferr_q;
endmodule

// File: doc/dsa_uart_cmd_engine.md
Name: dsa_uart_cmd_engine

Overview:
- Byte-stream command engine between the UART PHY pair (uart_rx/uart_tx, instantiated by the parent) and dsa_top.
- Next generation of the UART control interface:
  - parametrised address/length/counter widths
  - burst memory read/write with address auto-increment
  - per-frame XOR checksum
  - indexed counter readback
  - inter-byte timeout with NAK recovery

Parameters:
ADDR_W, 18, memory address width; address wraps modulo 2^ADDR_W.
LEN_W, 16, burst length field width; max burst 2^LEN_W-1 bytes.
NUM_CNT, 4, number of 32-bit counters on cnt_bus.
TIMEOUT_CYC, 500000, max idle cycles between received bytes inside a frame.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_valid  in  1  one-cycle pulse, rx_data valid; no backpressure
rx_data  in  8  received byte
tx_valid  out  1  byte offered to uart_tx
tx_data  out  8  byte to send; stable while tx_valid && !tx_ready
tx_ready  in  1  uart_tx accepts the byte when tx_valid && tx_ready
dsa_start  out  1  one-cycle start pulse
dsa_soft_rst  out  1  one-cycle soft-reset pulse
dsa_mode_simd  out  1  config: SIMD mode
dsa_img_width_in  out  10  config: width
dsa_img_height_in  out  10  config: height
dsa_scale_factor  out  8  config: Q-format scale
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe; mem_rdata valid exactly 1 cycle later
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  write data
mem_rdata  in  8  read data
dsa_busy  in  1  status
dsa_ready  in  1  status
dsa_error  in  1  status
dsa_progress  in  16  status
cnt_bus  in  NUM_CNT*32  counter i at bits [32*i +: 32]
frame_err  out  1  sticky: a checksum, timeout, unknown-command or rx-overrun error occurred; cleared by CMD_RESET

Behaviour:
- Reset values:
  - pulses, strobes, tx_valid, frame_err: 0
  - mem_addr, width, height, mode_simd: 0
  - scale_factor: 8'h80
  - state: IDLE
- Frame format: CMD, payload, CHK. CHK = XOR of CMD and all payload bytes (write data included). Multi-byte fields are little-endian.
- Commands:
  - 01 CONFIG, 4B payload: width=[31:22], height=[21:12], scale=[11:4], simd=[0].
  - 07 SET_ADDR, 4B payload: mem_addr = low ADDR_W bits.
  - 02 WRITE_BURST: payload is LEN_W/8 bytes of length L, then L data bytes. Each data byte drives mem_we for one cycle, the cycle after its rx_valid, at mem_addr; mem_addr then increments. Writes are not rolled back on a later checksum failure.
  - 03 READ_BURST: L, then CHK. After ACK, L bytes are streamed: per byte, mem_re pulse → wait 1 cycle → latch mem_rdata → transmit → mem_addr+1.
  - 04 START: dsa_start pulse. NAK if dsa_busy.
  - 05 STATUS: response {dsa_progress, 8'h0, 4'h0, frame_err, dsa_error, dsa_ready, dsa_busy}.
  - 06 COUNTER: 1B index; response cnt_bus word. Index >= NUM_CNT → NAK.
  - 08 RESET: dsa_soft_rst pulse; clears frame_err.
- Actions execute in EXEC, 1 cycle after the CHK byte. Config registers update only on a good checksum.
- Responses: ACK (AA), then the 4-byte response for STATUS/COUNTER (LSB first). Otherwise NAK (FF).
- L = 0 in a burst: no memory access; ACK only.
- State machine:
  - IDLE -(rx)-> LEN/PAYLOAD (or CHK for 0-payload commands)
  - PAYLOAD → WR_DATA (write burst) or CHK
  - CHK → EXEC
  - EXEC → SEND_ACK or SEND_NAK
  - SEND_ACK → SEND_RESP | RD_REQ | IDLE
  - RD_REQ → RD_WAIT → RD_SEND → RD_REQ or IDLE
  - SEND_NAK → IDLE
- Unknown CMD: immediate NAK, frame_err=1, back to IDLE without waiting for payload.
- Timeout: a cycle counter is cleared on every rx_valid and runs only in receive states. When it reaches TIMEOUT_CYC: NAK, frame_err=1, IDLE.
- Overrun: rx_valid in any transmit/read state is dropped and sets frame_err.
- Reset mid-frame: everything returns to reset values immediately; no partial transmission resumes.
- Address increment wraps 2^ADDR_W-1 → 0.

Decomposition:
- Package dsa_uart_pkg:
  - command codes
  - ACK/NAK constants
  - state enum
  - STATUS word layout localparams
- One sub-module, dsa_uart_frame_timer: loadable down-counter with clear and expire outputs, parameter TIMEOUT_CYC.
- Checksum accumulator and burst counter stay inline.

Test Plan:
- CONFIG payload 0x50078100, correct CHK → ACK; width=320, height=120, scale=0x10, simd=0.
- SET_ADDR 0x3FFFE, then WRITE_BURST L=3 data 11,22,33 → writes at 3FFFE, 3FFFF, 00000; ACK; mem_addr=1.
- SET_ADDR 0x100, then READ_BURST L=4 against a model memory holding 0xA0..A3 → AA A0 A1 A2 A3; exactly 4 mem_re pulses, each followed by a 1-cycle latency.
- CONFIG with CHK off by one bit → FF; config registers unchanged; frame_err=1. STATUS then shows bit3=1. RESET → ACK; dsa_soft_rst pulse; frame_err=0.
- COUNTER idx=2 with cnt_bus word2=0xDEADBEEF → AA EF BE AD DE. idx=4 → FF.
- Send CMD 02 then stall TIMEOUT_CYC cycles → FF; IDLE. A following STATUS frame succeeds. Asserting rst during a READ_BURST immediately drops tx_valid and mem_re.
